// File: rtl/countdown_timer9bit.sv
// Loadable down-counter/timer with one-shot or auto-reload expiry, a one-cycle
// done pulse, a sticky expired flag and a saturating count of reload expiries.
module countdown_timer9bit #(
    parameter int WIDTH = 9,
    parameter int RLDW  = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             enable,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             expired,
    output logic [RLDW-1:0]  reload_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [RLDW-1:0]  RLD_ONE = RLDW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_preset;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_expired;
    logic [RLDW-1:0]  r_reload_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_preset_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_expired_nxt;
    logic [RLDW-1:0]  w_reload_nxt;
    logic [WIDTH-1:0] w_preset_eff;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state      <= S_IDLE;
            r_preset     <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_expired    <= 1'b0;
            r_reload_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_preset     <= w_preset_nxt;
            r_count      <= w_count_nxt;
            r_busy       <= (w_state_nxt == S_RUN);
            r_done       <= w_done_nxt;
            r_expired    <= w_expired_nxt;
            r_reload_cnt <= w_reload_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_preset_nxt  = r_preset;
        w_count_nxt   = r_count;
        w_done_nxt    = 1'b0;
        w_expired_nxt = r_expired;
        w_reload_nxt  = r_reload_cnt;
        // A start in the same cycle as a load must see the new preset.
        w_preset_eff  = load ? load_value : r_preset;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (load) begin
                    w_preset_nxt = load_value;
                    w_count_nxt  = load_value;
                end
                if (start) begin
                    if (w_preset_eff != '0) begin
                        w_count_nxt   = w_preset_eff;
                        w_expired_nxt = 1'b0;
                        w_reload_nxt  = '0;
                        w_state_nxt   = S_RUN;
                    end else begin
                        w_count_nxt   = '0;
                        w_done_nxt    = 1'b1;
                        w_expired_nxt = 1'b1;
                        w_state_nxt   = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (enable) begin
                    if (r_count == CNT_ONE) begin
                        w_done_nxt    = 1'b1;
                        w_expired_nxt = 1'b1;
                        if (reload_en) begin
                            w_count_nxt = r_preset;
                            if (r_reload_cnt != '1) begin
                                w_reload_nxt = r_reload_cnt + RLD_ONE;
                            end
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_count_nxt = r_count - CNT_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign count      = r_count;
    assign busy       = r_busy;
    assign done       = r_done;
    assign expired    = r_expired;
    assign reload_cnt = r_reload_cnt;

endmodule

// File: tb/tb_countdown_timer9bit.sv
// Scoreboard bench for countdown_timer9bit: directed stimulus queues the expected
// post-edge outputs; a monitor pops one entry after each rising edge and compares.
module tb_countdown_timer9bit;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       load = 1'b0;
    logic [8:0] load_value = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       enable = 1'b0;
    logic       reload_en = 1'b0;
    logic [8:0] count;
    logic       busy;
    logic       done;
    logic       expired;
    logic [3:0] reload_cnt;

    typedef struct {
        string      nm;
        logic [8:0] c;
        logic       b;
        logic       d;
        logic       e;
        logic [3:0] r;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   passed = 0;
    int   total = 0;
    int   rc = 0;
    int   n = 0;

    countdown_timer9bit #(.WIDTH(9), .RLDW(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .stop       (stop),
        .enable     (enable),
        .reload_en  (reload_en),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .expired    (expired),
        .reload_cnt (reload_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            m_e = q.pop_front();
            total++;
            if (count === m_e.c && busy === m_e.b && done === m_e.d &&
                expired === m_e.e && reload_cnt === m_e.r) begin
                passed++;
            end else begin
                $display("FAIL %s: got count=%0d busy=%b done=%b expired=%b reload_cnt=%0d, want count=%0d busy=%b done=%b expired=%b reload_cnt=%0d",
                         m_e.nm, count, busy, done, expired, reload_cnt,
                         m_e.c, m_e.b, m_e.d, m_e.e, m_e.r);
            end
        end
    end

    // Inputs are already driven for the coming edge; queue what that edge must produce.
    task automatic cyc(input string nm, input int c, input bit b, input bit d,
                       input bit e, input int r);
        exp_t x;
        x.nm = nm;
        x.c  = 9'(c);
        x.b  = b;
        x.d  = d;
        x.e  = e;
        x.r  = 4'(r);
        q.push_back(x);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        clear = 1'b1;
        cyc("reset", 0, 0, 0, 0, 0);
        clear = 1'b0;

        // Reset in the middle of a run
        load = 1'b1; load_value = 9'd20;
        cyc("ld20", 20, 0, 0, 0, 0);
        load = 1'b0; start = 1'b1; enable = 1'b1;
        cyc("start20", 20, 1, 0, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 5; i++) cyc("run20", 20 - i, 1, 0, 0, 0);
        clear = 1'b1;
        cyc("clear_mid_run", 0, 0, 0, 0, 0);
        clear = 1'b0; start = 1'b1;
        cyc("start_preset0", 0, 0, 1, 1, 0);
        start = 1'b0;
        cyc("preset0_single_done", 0, 0, 0, 1, 0);

        // One-shot, preset 5
        load = 1'b1; load_value = 9'd5;
        cyc("ld5_in_done", 5, 0, 0, 1, 0);
        load = 1'b0; start = 1'b1;
        cyc("start5", 5, 1, 0, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) cyc("run5", 5 - i, 1, 0, 0, 0);
        cyc("expire5", 0, 0, 1, 1, 0);
        cyc("after5_a", 0, 0, 0, 1, 0);
        cyc("after5_b", 0, 0, 0, 1, 0);

        // Enable gating, preset 10
        load = 1'b1; load_value = 9'd10;
        cyc("ld10", 10, 0, 0, 1, 0);
        load = 1'b0; start = 1'b1;
        cyc("start10", 10, 1, 0, 0, 0);
        start = 1'b0;
        n = 0;
        for (int k = 0; k <= 18; k++) begin
            enable = (k % 2 == 0);
            if (enable) n++;
            if (n == 10 && enable) cyc("expire10", 0, 0, 1, 1, 0);
            else cyc("gated10", 10 - n, 1, 0, 0, 0);
        end
        enable = 1'b1;
        cyc("after10", 0, 0, 0, 1, 0);

        // Stop at 7
        start = 1'b1;
        cyc("restart10", 10, 1, 0, 0, 0);
        start = 1'b0;
        for (int i = 1; i <= 3; i++) cyc("run10b", 10 - i, 1, 0, 0, 0);
        stop = 1'b1;
        cyc("stop_at7", 7, 0, 0, 0, 0);
        cyc("stop_in_idle", 7, 0, 0, 0, 0);
        stop = 1'b0;
        cyc("hold7", 7, 0, 0, 0, 0);

        // Auto-reload, preset 3
        load = 1'b1; load_value = 9'd3; reload_en = 1'b1;
        cyc("ld3", 3, 0, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("start3", 3, 1, 0, 0, 0);
        start = 1'b0;
        rc = 0;
        for (int k = 1; k <= 60; k++) begin
            if (k % 3 == 0) begin
                if (rc < 15) rc++;
                cyc("reload_tick", 3, 1, 1, 1, rc);
            end else begin
                cyc("reload_run", 3 - (k % 3), 1, 0, (k >= 3), rc);
            end
        end
        stop = 1'b1;
        cyc("stop_reload", 3, 0, 0, 1, 15);
        stop = 1'b0; reload_en = 1'b0;

        // Maximum preset, with load/start attempts mid-run
        load = 1'b1; load_value = 9'd511;
        cyc("ld511", 511, 0, 0, 1, 15);
        load = 1'b0; start = 1'b1;
        cyc("start511", 511, 1, 0, 0, 0);
        start = 1'b0;
        for (int k = 1; k <= 510; k++) begin
            if (k == 100) begin
                load = 1'b1; load_value = 9'd50; start = 1'b1;
            end else begin
                load = 1'b0; start = 1'b0;
            end
            cyc("run511", 511 - k, 1, 0, 0, 0);
        end
        cyc("expire511", 0, 0, 1, 1, 0);
        start = 1'b1;
        cyc("preset_kept511", 511, 1, 0, 0, 0);
        start = 1'b0; stop = 1'b1;
        cyc("stop511", 511, 0, 0, 0, 0);
        stop = 1'b0;

        // Preset 1
        load = 1'b1; load_value = 9'd1;
        cyc("ld1", 1, 0, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("start1", 1, 1, 0, 0, 0);
        start = 1'b0;
        cyc("expire1", 0, 0, 1, 1, 0);

        // Load and start together, with an enable hold
        load = 1'b1; load_value = 9'd4; start = 1'b1;
        cyc("ldstart4", 4, 1, 0, 0, 0);
        load = 1'b0; start = 1'b0; enable = 1'b0;
        cyc("hold4", 4, 1, 0, 0, 0);
        enable = 1'b1;
        for (int i = 1; i <= 3; i++) cyc("run4", 4 - i, 1, 0, 0, 0);
        cyc("expire4", 0, 0, 1, 1, 0);
        cyc("after4", 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
